pixel_pair_tx: RTL and testbench
================================

PIXEL_PAIR_TX -- requirements
Module: pixel_pair_tx

Interface
REQ-001 SHALL have parameter H_ACT, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 16: idle cycles after each line, min 1.
REQ-004 SHALL have parameter V_BLANK, default 64: idle cycles after each frame, min 1.
REQ-005 SHALL have port clk_pixl, in, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset, in, 1: reset is asynchronous and active-low.
REQ-007 SHALL have port enable_i, in, 1: start and continue frame generation.
REQ-008 SHALL have ports dvi_valid_i in 1, dvi_ready_o out 1, dvi_rgb_i in 16: DVI RGB565 source.
REQ-009 SHALL have ports ccd_valid_i in 1, ccd_ready_o out 1, ccd_rgb_i in 16: CCD RGB565 source.
REQ-010 SHALL have port valid_o, out, 1: output pixel qualifier.
REQ-011 SHALL have ports syncX_o out 10 and syncY_o out 10: pixel coordinates.
REQ-012 SHALL have ports DVI_R_o out 5, DVI_G_o out 6, DVI_B_o out 5: DVI pixel.
REQ-013 SHALL have ports CCD_R_o out 5, CCD_G_o out 6, CCD_B_o out 5: CCD pixel.
REQ-014 SHALL have port frame_done_o, out, 1: one-cycle pulse with the last pixel of a frame.
REQ-015 SHALL have port stall_cnt_o, out, 16: stall cycles in the current frame, saturating.

Function
REQ-016 SHALL implement FSM states IDLE, ACTIVE, HBLANK, VBLANK.
REQ-017 IDLE -> ACTIVE SHALL occur on the first cycle enable_i=1; x=0 and y=0 at entry.
REQ-018 SHALL assert dvi_ready_o and ccd_ready_o together, only in ACTIVE when dvi_valid_i=1 and ccd_valid_i=1 (join handshake); a transfer is that cycle.
REQ-019 Each transfer SHALL register valid_o=1 next cycle with syncX_o=x, syncY_o=y and RGB565 split {R[15:11],G[10:5],B[4:0]} per source; latency is exactly 1 cycle.
REQ-020 Cycles with no transfer SHALL drive valid_o=0; syncX_o, syncY_o and the RGB outputs SHALL hold their last values.
REQ-021 An ACTIVE cycle with either source not valid SHALL increment stall_cnt_o, saturating at 16'hFFFF; a lone valid source SHALL NOT be consumed.
REQ-022 A transfer with x=H_ACT-1 and y<V_ACT-1 SHALL set x=0, y=y+1 and go to HBLANK.
REQ-023 HBLANK SHALL last exactly H_BLANK cycles with both readies low, then return to ACTIVE.
REQ-024 A transfer at x=H_ACT-1, y=V_ACT-1 SHALL pulse frame_done_o in the same cycle as that pixel's valid_o, clear x and y, and go to VBLANK.
REQ-025 After V_BLANK cycles, VBLANK SHALL go to ACTIVE if enable_i=1, else to IDLE.
REQ-026 stall_cnt_o SHALL clear to 0 on the first ACTIVE cycle of each frame.
REQ-027 Deassertion of enable_i mid-frame SHALL NOT truncate the frame; the frame completes and the FSM then goes to IDLE.
REQ-028 Coordinates SHALL wrap only as in REQ-022/REQ-024; x never exceeds H_ACT-1 and y never exceeds V_ACT-1.

Reset
REQ-029 While reset=0: state=IDLE, x=y=0, valid_o=0, frame_done_o=0, both readies 0, syncX_o=syncY_o=0, all RGB outputs 0, stall_cnt_o=0.
REQ-030 Reset mid-frame SHALL abandon the frame; after release, output starts at x=0, y=0, with no partial frame_done_o.

Structure
REQ-031 Shared package SHALL hold the FSM state typedef, default H_ACT/V_ACT/H_BLANK/V_BLANK constants and RGB565 field positions.
REQ-032 Sub-module pixel_raster_cnt SHALL hold the x/y counters, the blank-cycle counter and the last-pixel/end-of-line flags; the FSM and output registers stay in pixel_pair_tx.

Verification
REQ-033 Both sources always valid, enable_i=1 -> 307200 valid_o pulses per frame, x 0..639 and y 0..479 in order, one frame_done_o at (639,479), stall_cnt_o=0.
REQ-034 Pixel dvi_rgb_i=16'hF81F, ccd_rgb_i=16'h07E0 at (5,0) -> DVI_R_o=31, DVI_G_o=0, DVI_B_o=31, CCD_G_o=63, CCD_R_o=CCD_B_o=0, one cycle after the transfer.
REQ-035 ccd_valid_i low for 10 cycles mid-line while dvi_valid_i high -> no readies, valid_o=0 for 10 cycles, stall_cnt_o +10, no DVI pixel lost.
REQ-036 End of line 0 -> exactly 16 cycles with valid_o=0 and readies low, then (0,1) emitted.
REQ-037 enable_i dropped at (100,200) -> frame completes to (639,479), VBLANK 64 cycles, then IDLE with readies low.
REQ-038 reset pulsed at (300,100) -> all outputs zero during reset; after release and enable_i=1, first pixel is (0,0).

Source files
------------

// File: rtl/pixel_pair_tx_pkg.sv
// Shared types and constants for the pixel pair transmitter.
// No logic; no latency.
// No flow control of its own.
package pixel_pair_tx_pkg;

    // Frame generator states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    // Default raster geometry (640x480 active area)
    localparam int DEF_H_ACT   = 640;
    localparam int DEF_V_ACT   = 480;
    localparam int DEF_H_BLANK = 16;
    localparam int DEF_V_BLANK = 64;

    // Counter widths
    localparam int COORD_W = 10;
    localparam int BLANK_W = 16;
    localparam int STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

    // RGB565 field positions within a 16-bit source word
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Split a raw RGB565 word into its colour fields
    function automatic rgb565_t split_rgb565(input logic [15:0] d);
        rgb565_t px;
        px.r = d[RGB_R_MSB:RGB_R_LSB];
        px.g = d[RGB_G_MSB:RGB_G_LSB];
        px.b = d[RGB_B_MSB:RGB_B_LSB];
        return px;
    endfunction

endpackage

// File: rtl/pixel_raster_cnt.sv
// Raster position (x/y) and blanking-interval counters with end-of-line/frame flags.
// Flags are combinational from registered counters; counters update one cycle after a step.
// No backpressure; advances only when told to step or while blanking.
module pixel_raster_cnt
    import pixel_pair_tx_pkg::*;
#(
    parameter int H_ACT   = DEF_H_ACT,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int V_BLANK = DEF_V_BLANK
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_step,
    input  logic               i_blank_h,
    input  logic               i_blank_v,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_eol,
    output logic               o_last,
    output logic               o_blank_done
);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [BLANK_W-1:0] r_blank;
    logic               w_eol;
    logic               w_last_line;

    assign w_eol       = (r_x == COORD_W'(H_ACT - 1));
    assign w_last_line = (r_y == COORD_W'(V_ACT - 1));

    // Advance the raster position on each transfer; wrap at end of line and end of frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            if (w_eol) begin
                r_x <= '0;
                r_y <= w_last_line ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Count cycles spent blanking; parked at zero otherwise so every interval starts fresh
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blank <= '0;
        end else if (i_blank_h || i_blank_v) begin
            r_blank <= r_blank + 1'b1;
        end else begin
            r_blank <= '0;
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_eol        = w_eol;
    assign o_last       = w_eol && w_last_line;
    assign o_blank_done = (i_blank_h && (r_blank == BLANK_W'(H_BLANK - 1))) ||
                          (i_blank_v && (r_blank == BLANK_W'(V_BLANK - 1)));

endmodule

// File: rtl/pixel_pair_tx.sv
// Joins DVI and CCD RGB565 streams into a rastered pixel-pair output with coordinates.
// Output registered: pixel appears exactly 1 cycle after the joint transfer.
// Both sources are readied together only when both are valid in ACTIVE; a lone valid source waits.
module pixel_pair_tx
    import pixel_pair_tx_pkg::*;
#(
    parameter int H_ACT   = DEF_H_ACT,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int V_BLANK = DEF_V_BLANK
) (
    input  logic                clk_pixl,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                dvi_valid_i,
    output logic                dvi_ready_o,
    input  logic [15:0]         dvi_rgb_i,
    input  logic                ccd_valid_i,
    output logic                ccd_ready_o,
    input  logic [15:0]         ccd_rgb_i,
    output logic                valid_o,
    output logic [COORD_W-1:0]  syncX_o,
    output logic [COORD_W-1:0]  syncY_o,
    output logic [4:0]          DVI_R_o,
    output logic [5:0]          DVI_G_o,
    output logic [4:0]          DVI_B_o,
    output logic [4:0]          CCD_R_o,
    output logic [5:0]          CCD_G_o,
    output logic [4:0]          CCD_B_o,
    output logic                frame_done_o,
    output logic [STALL_W-1:0]  stall_cnt_o
);

    state_t              r_state;
    state_t              w_state_d;
    logic                w_xfer;
    logic                w_blank_h;
    logic                w_blank_v;
    logic                w_stall;
    logic                w_frame_start;
    logic [COORD_W-1:0]  w_x;
    logic [COORD_W-1:0]  w_y;
    logic                w_eol;
    logic                w_last;
    logic                w_blank_done;

    logic                r_valid;
    logic                r_frame_done;
    logic                r_first_act;
    logic [COORD_W-1:0]  r_sync_x;
    logic [COORD_W-1:0]  r_sync_y;
    rgb565_t             r_dvi_px;
    rgb565_t             r_ccd_px;
    logic [STALL_W-1:0]  r_stall;

    pixel_raster_cnt #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK)
    ) u_raster (
        .i_clk        (clk_pixl),
        .i_rst_n      (reset),
        .i_step       (w_xfer),
        .i_blank_h    (w_blank_h),
        .i_blank_v    (w_blank_v),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_eol        (w_eol),
        .o_last       (w_last),
        .o_blank_done (w_blank_done)
    );

    // State register
    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state, join handshake and blanking control
    always_comb begin
        w_state_d = r_state;
        w_xfer    = 1'b0;
        w_blank_h = 1'b0;
        w_blank_v = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_xfer = dvi_valid_i && ccd_valid_i;
                if (w_xfer && w_last) begin
                    w_state_d = ST_VBLANK;
                end else if (w_xfer && w_eol) begin
                    w_state_d = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                w_blank_h = 1'b1;
                if (w_blank_done) begin
                    w_state_d = ST_ACTIVE;
                end
            end
            ST_VBLANK: begin
                w_blank_v = 1'b1;
                // enable_i is only sampled here, so dropping it mid-frame lets the frame finish
                if (w_blank_done) begin
                    w_state_d = enable_i ? ST_ACTIVE : ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign dvi_ready_o   = w_xfer;
    assign ccd_ready_o   = w_xfer;
    assign w_stall       = (r_state == ST_ACTIVE) && !w_xfer;
    assign w_frame_start = ((r_state == ST_IDLE) || (r_state == ST_VBLANK)) &&
                           (w_state_d == ST_ACTIVE);

    // Register the joined pixel and its coordinates; hold them between transfers
    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_x     <= '0;
            r_sync_y     <= '0;
            r_dvi_px     <= '0;
            r_ccd_px     <= '0;
        end else begin
            r_valid      <= w_xfer;
            r_frame_done <= w_xfer && w_last;
            if (w_xfer) begin
                r_sync_x <= w_x;
                r_sync_y <= w_y;
                r_dvi_px <= split_rgb565(dvi_rgb_i);
                r_ccd_px <= split_rgb565(ccd_rgb_i);
            end
        end
    end

    // Per-frame stall counter: restarts on the first ACTIVE cycle of a frame, saturates at max
    always_ff @(posedge clk_pixl or negedge reset) begin
        if (!reset) begin
            r_first_act <= 1'b0;
            r_stall     <= '0;
        end else begin
            r_first_act <= w_frame_start;
            if (r_first_act) begin
                r_stall <= w_stall ? STALL_W'(1) : '0;
            end else if (w_stall && (r_stall != STALL_MAX)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign valid_o      = r_valid;
    assign frame_done_o = r_frame_done;
    assign syncX_o      = r_sync_x;
    assign syncY_o      = r_sync_y;
    assign DVI_R_o      = r_dvi_px.r;
    assign DVI_G_o      = r_dvi_px.g;
    assign DVI_B_o      = r_dvi_px.b;
    assign CCD_R_o      = r_ccd_px.r;
    assign CCD_G_o      = r_ccd_px.g;
    assign CCD_B_o      = r_ccd_px.b;
    assign stall_cnt_o  = r_stall;

endmodule

// File: tb/tb_pixel_pair_tx.sv
// Scoreboard bench for pixel_pair_tx on a reduced 8x4 raster with full-size blanking.
// Stimulus pushes expected pixels at each joint handshake; a monitor pops on valid_o.
// Directed sections cover reset, line/frame blanking, stalls, enable drop and mid-frame reset.
module tb_pixel_pair_tx;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HB = 16;
    localparam int VB = 64;

    logic        clk_pixl = 1'b0;
    logic        reset;
    logic        enable_i;
    logic        dvi_valid_i;
    logic        dvi_ready_o;
    logic [15:0] dvi_rgb_i;
    logic        ccd_valid_i;
    logic        ccd_ready_o;
    logic [15:0] ccd_rgb_i;
    logic        valid_o;
    logic [9:0]  syncX_o;
    logic [9:0]  syncY_o;
    logic [4:0]  DVI_R_o;
    logic [5:0]  DVI_G_o;
    logic [4:0]  DVI_B_o;
    logic [4:0]  CCD_R_o;
    logic [5:0]  CCD_G_o;
    logic [4:0]  CCD_B_o;
    logic        frame_done_o;
    logic [15:0] stall_cnt_o;

    pixel_pair_tx #(
        .H_ACT   (H),
        .V_ACT   (V),
        .H_BLANK (HB),
        .V_BLANK (VB)
    ) dut (
        .clk_pixl     (clk_pixl),
        .reset        (reset),
        .enable_i     (enable_i),
        .dvi_valid_i  (dvi_valid_i),
        .dvi_ready_o  (dvi_ready_o),
        .dvi_rgb_i    (dvi_rgb_i),
        .ccd_valid_i  (ccd_valid_i),
        .ccd_ready_o  (ccd_ready_o),
        .ccd_rgb_i    (ccd_rgb_i),
        .valid_o      (valid_o),
        .syncX_o      (syncX_o),
        .syncY_o      (syncY_o),
        .DVI_R_o      (DVI_R_o),
        .DVI_G_o      (DVI_G_o),
        .DVI_B_o      (DVI_B_o),
        .CCD_R_o      (CCD_R_o),
        .CCD_G_o      (CCD_G_o),
        .CCD_B_o      (CCD_B_o),
        .frame_done_o (frame_done_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_pixl = ~clk_pixl;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] dvi;
        logic [15:0] ccd;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_pix   = 0;
    int n_fd    = 0;
    int n_push  = 0;
    int n_ready = 0;
    int gap     = 0;
    int last_gap = 0;
    int mx = 0;
    int my = 0;

    function automatic logic [15:0] pix_dvi(input int x, input int y);
        if (x == 5 && y == 0) return 16'hF81F;
        return 16'(x * 97 + y * 1031 + 4660);
    endfunction

    function automatic logic [15:0] pix_ccd(input int x, input int y);
        if (x == 5 && y == 0) return 16'h07E0;
        return 16'((x * 211) ^ (y * 53) ^ 16'hA5C3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: present data for the model's next pixel, observe the handshake
    task automatic tick();
        exp_t e;
        dvi_rgb_i = pix_dvi(mx, my);
        ccd_rgb_i = pix_ccd(mx, my);
        @(negedge clk_pixl);
        n_cmp++;
        if ((dvi_ready_o !== ccd_ready_o) ||
            (dvi_ready_o === 1'b1 && !(dvi_valid_i && ccd_valid_i))) begin
            n_bad++;
            $display("FAIL ready_join: got dvi_ready=%b ccd_ready=%b with dvi_valid=%b ccd_valid=%b",
                     dvi_ready_o, ccd_ready_o, dvi_valid_i, ccd_valid_i);
        end
        if (dvi_ready_o === 1'b1) begin
            e.x   = 10'(mx);
            e.y   = 10'(my);
            e.dvi = dvi_rgb_i;
            e.ccd = ccd_rgb_i;
            e.fd  = (mx == H - 1) && (my == V - 1);
            sb.push_back(e);
            n_push++;
            n_ready++;
            last_gap = gap;
            gap = 0;
            if (mx == H - 1) begin
                mx = 0;
                my = (my == V - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end else begin
            gap++;
        end
        @(posedge clk_pixl);
        #1;
    endtask

    // Tick until the model's next pixel is (tx,ty); a stuck DUT counts as a failure
    task automatic run_until(input int tx, input int ty, input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(mx == tx && my == ty) && k < 2000);
        n_cmp++;
        if (!(mx == tx && my == ty)) begin
            n_bad++;
            $display("FAIL %s: no progress, stopped at (%0d,%0d), required (%0d,%0d)",
                     name, mx, my, tx, ty);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 64'({valid_o, frame_done_o, dvi_ready_o, ccd_ready_o, syncX_o, syncY_o}), 64'd0);
        check({name, "_rgb"}, 64'({DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o}), 64'd0);
        check({name, "_stall"}, 64'(stall_cnt_o), 64'd0);
    endtask

    // Monitor: every valid_o pops one expected pixel
    always @(negedge clk_pixl) begin
        if (valid_o === 1'b1) begin
            n_pix++;
            if (frame_done_o === 1'b1) n_fd++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pixel: got valid_o at (%0d,%0d), required no output",
                         syncX_o, syncY_o);
            end else begin
                e_mon = sb.pop_front();
                if ({syncX_o, syncY_o, DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o, frame_done_o} !==
                    {e_mon.x, e_mon.y, 5'(e_mon.dvi >> 11), 6'(e_mon.dvi >> 5), 5'(e_mon.dvi),
                     5'(e_mon.ccd >> 11), 6'(e_mon.ccd >> 5), 5'(e_mon.ccd), e_mon.fd}) begin
                    n_bad++;
                    $display("FAIL pixel: got (%0d,%0d) dvi=%0d/%0d/%0d ccd=%0d/%0d/%0d fd=%b, required (%0d,%0d) dvi=%h ccd=%h fd=%b",
                             syncX_o, syncY_o, DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o,
                             frame_done_o, e_mon.x, e_mon.y, e_mon.dvi, e_mon.ccd, e_mon.fd);
                end
                if (e_mon.x == 10'd5 && e_mon.y == 10'd0) begin
                    n_cmp++;
                    if ({DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o} !==
                        {5'd31, 6'd0, 5'd31, 5'd0, 6'd63, 5'd0}) begin
                        n_bad++;
                        $display("FAIL rgb_split_5_0: got %0d/%0d/%0d %0d/%0d/%0d, required 31/0/31 0/63/0",
                                 DVI_R_o, DVI_G_o, DVI_B_o, CCD_R_o, CCD_G_o, CCD_B_o);
                    end
                end
            end
        end else begin
            n_cmp++;
            if (frame_done_o !== 1'b0) begin
                n_bad++;
                $display("FAIL frame_done_alone: got frame_done_o=%b without valid_o, required 0", frame_done_o);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        reset       = 1'b0;
        enable_i    = 1'b0;
        dvi_valid_i = 1'b0;
        ccd_valid_i = 1'b0;
        dvi_rgb_i   = '0;
        ccd_rgb_i   = '0;

        // Reset state
        repeat (3) @(negedge clk_pixl);
        check_all_zero("reset");
        @(posedge clk_pixl);
        #1;
        reset       = 1'b1;
        dvi_valid_i = 1'b1;
        ccd_valid_i = 1'b1;

        // IDLE holds off both sources while disabled
        r0 = n_ready;
        repeat (5) tick();
        check("idle_no_ready", 64'(n_ready - r0), 64'd0);

        // Frame 1: both sources always valid
        enable_i = 1'b1;
        run_until(6, 0, "f1_to_6_0");
        run_until(0, 1, "f1_line0");
        run_until(1, 1, "f1_to_1_1");
        check("hblank_gap", 64'(last_gap), 64'(HB));
        run_until(0, 0, "f1_end");
        tick();
        check("f1_pixels", 64'(n_pix), 64'(H * V));
        check("f1_frame_done", 64'(n_fd), 64'd1);
        check("f1_stall", 64'(stall_cnt_o), 64'd0);

        // Frame 2: VBLANK length, then a CCD stall mid-line
        run_until(1, 0, "f2_start");
        check("vblank_gap", 64'(last_gap), 64'(VB));
        run_until(3, 1, "f2_to_3_1");
        s0 = int'(stall_cnt_o);
        r0 = n_ready;
        ccd_valid_i = 1'b0;
        repeat (10) tick();
        ccd_valid_i = 1'b1;
        check("stall_no_ready", 64'(n_ready - r0), 64'd0);
        check("stall_count", 64'(stall_cnt_o), 64'(s0 + 10));

        // Drop enable mid-frame: frame completes, VBLANK, then IDLE
        run_until(5, 2, "f2_to_5_2");
        enable_i = 1'b0;
        run_until(0, 0, "f2_end_after_disable");
        r0 = n_ready;
        repeat (VB + 20) tick();
        check("disabled_no_ready", 64'(n_ready - r0), 64'd0);
        check("f2_frame_done", 64'(n_fd), 64'd2);
        check("f2_stall_kept", 64'(stall_cnt_o), 64'd10);

        // Frame 3: re-enable from IDLE, stall counter restarts
        enable_i = 1'b1;
        run_until(1, 0, "f3_start");
        check("idle_restart_gap", 64'(last_gap), 64'(VB + 21));
        check("f3_stall_cleared", 64'(stall_cnt_o), 64'd0);

        // Mid-frame reset abandons the frame
        run_until(3, 2, "f3_to_3_2");
        dvi_valid_i = 1'b0;
        ccd_valid_i = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_sb_empty", 64'(sb.size()), 64'd0);
        mx = 0;
        my = 0;
        repeat (3) @(posedge clk_pixl);
        #1;
        check_all_zero("midreset_hold");
        reset       = 1'b1;
        dvi_valid_i = 1'b1;
        ccd_valid_i = 1'b1;

        // Frame 4: starts at (0,0) and runs to completion
        run_until(1, 0, "f4_start");
        run_until(0, 0, "f4_end");
        tick();
        check("total_frame_done", 64'(n_fd), 64'd3);
        check("all_popped", 64'(sb.size()), 64'd0);
        check("pix_vs_push", 64'(n_pix), 64'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
